// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Initiator side of the ALU interface. Accepts one
//               register-to-register instruction at a time, reads operands
//               from an internal register file, drives the ALU, captures its
//               registered status and writes the result back.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int NUM_BITS      = 16,
  parameter int OP_BITS       = 4,
  parameter int REG_ADDR_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_BITS-1:0]       in_op,
  input  logic [REG_ADDR_BITS-1:0] in_rd,
  input  logic [REG_ADDR_BITS-1:0] in_rs1,
  input  logic [REG_ADDR_BITS-1:0] in_rs2,
  input  logic                     ld_en,
  input  logic [REG_ADDR_BITS-1:0] ld_addr,
  input  logic [NUM_BITS-1:0]      ld_data,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [NUM_BITS-1:0]      dbg_data,
  output logic [OP_BITS-1:0]       alu_operator,
  output logic [NUM_BITS-1:0]      alu_op1,
  output logic [NUM_BITS-1:0]      alu_op2,
  input  logic [NUM_BITS-1:0]      alu_status,
  output logic                     done,
  output logic [NUM_BITS-1:0]      result,
  output logic [1:0]               err
);

  localparam int               c_NUM_REGS = 1 << REG_ADDR_BITS;
  localparam logic [OP_BITS-1:0] c_OP_NOP  = {OP_BITS{1'b1}};
  localparam logic [OP_BITS-1:0] c_OP_DIV  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] c_OP_MOD  = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] c_OP_LAST = OP_BITS'(7);
  localparam logic [1:0]         c_ERR_OK  = 2'd0;
  localparam logic [1:0]         c_ERR_OPC = 2'd1;
  localparam logic [1:0]         c_ERR_DIV = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t                     r_state;
  logic [OP_BITS-1:0]         r_op;
  logic [REG_ADDR_BITS-1:0]   r_rd;
  logic [REG_ADDR_BITS-1:0]   r_rs1;
  logic [REG_ADDR_BITS-1:0]   r_rs2;
  logic [1:0]                 r_err_pend;
  logic [OP_BITS-1:0]         r_hold_operator;
  logic [NUM_BITS-1:0]        r_hold_op1;
  logic [NUM_BITS-1:0]        r_hold_op2;
  logic                       r_done;
  logic [NUM_BITS-1:0]        r_result;
  logic [1:0]                 r_err;
  logic [NUM_BITS-1:0]        r_rf [c_NUM_REGS];

  logic [NUM_BITS-1:0]        w_rs1_val;
  logic [NUM_BITS-1:0]        w_rs2_val;
  logic [1:0]                 w_issue_err;
  logic                       w_wb_we;

  // Operands are read straight from the register file while in ISSUE.
  assign w_rs1_val = r_rf[r_rs1];
  assign w_rs2_val = r_rf[r_rs2];
  assign dbg_data  = r_rf[dbg_addr];
  assign in_ready  = (r_state == S_IDLE);
  assign w_wb_we   = (r_state == S_WB) && (r_err_pend == c_ERR_OK);
  assign done      = r_done;
  assign result    = r_result;
  assign err       = r_err;

  // Classify the latched instruction: illegal opcode, divide/mod by zero, or ok.
  always_comb begin
    w_issue_err = c_ERR_OK;
    if (r_op > c_OP_LAST) begin
      w_issue_err = c_ERR_OPC;
    end else if (((r_op == c_OP_DIV) || (r_op == c_OP_MOD)) && (w_rs2_val == '0)) begin
      w_issue_err = c_ERR_DIV;
    end
  end

  // ALU drive: live operands in ISSUE, held copy in WB, NOP/0/0 otherwise.
  always_comb begin
    alu_operator = c_OP_NOP;
    alu_op1      = '0;
    alu_op2      = '0;
    case (r_state)
      S_ISSUE: begin
        alu_operator = (w_issue_err != c_ERR_OK) ? c_OP_NOP : r_op;
        alu_op1      = w_rs1_val;
        alu_op2      = w_rs2_val;
      end
      S_WB: begin
        alu_operator = r_hold_operator;
        alu_op1      = r_hold_op1;
        alu_op2      = r_hold_op2;
      end
      default: begin
        alu_operator = c_OP_NOP;
      end
    endcase
  end

  // Issue sequencer: IDLE -> ISSUE -> WB -> IDLE with registered retire outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_op            <= c_OP_NOP;
      r_rd            <= '0;
      r_rs1           <= '0;
      r_rs2           <= '0;
      r_err_pend      <= c_ERR_OK;
      r_hold_operator <= c_OP_NOP;
      r_hold_op1      <= '0;
      r_hold_op2      <= '0;
      r_done          <= 1'b0;
      r_result        <= '0;
      r_err           <= c_ERR_OK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= in_op;
            r_rd    <= in_rd;
            r_rs1   <= in_rs1;
            r_rs2   <= in_rs2;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Snapshot what was driven so WB holds it even if the rf changes.
          r_hold_operator <= alu_operator;
          r_hold_op1      <= alu_op1;
          r_hold_op2      <= alu_op2;
          r_err_pend      <= w_issue_err;
          r_state         <= S_WB;
        end
        S_WB: begin
          r_done   <= 1'b1;
          r_result <= (r_err_pend == c_ERR_OK) ? alu_status : '0;
          r_err    <= r_err_pend;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: direct loads in any state; a same-edge writeback overrides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        r_rf[ld_addr] <= ld_data;
      end
      if (w_wb_we) begin
        r_rf[r_rd] <= alu_status;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 16-bit ALU interface.
- Accepts register-to-register instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operator/op1/op2 inputs, captures the ALU's registered status result and writes it back to the register file.
- Sits between the instruction source and the ALU; one instruction in flight at a time.

Parameters:
- NUM_BITS, 16, data width of operands, results and register file entries
- OP_BITS, 4, operator width
- REG_ADDR_BITS, 3, register file address width (2**REG_ADDR_BITS entries)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  instruction valid
- in_ready  output  1  controller can accept an instruction
- in_op  input  OP_BITS  ALU operator code
- in_rd  input  REG_ADDR_BITS  destination register
- in_rs1  input  REG_ADDR_BITS  source register for op1
- in_rs2  input  REG_ADDR_BITS  source register for op2
- ld_en  input  1  direct register load strobe
- ld_addr  input  REG_ADDR_BITS  load address
- ld_data  input  NUM_BITS  load data
- dbg_addr  input  REG_ADDR_BITS  debug read address
- dbg_data  output  NUM_BITS  combinational read of rf[dbg_addr]
- alu_operator  output  OP_BITS  to ALU operator
- alu_op1  output  NUM_BITS  to ALU op1
- alu_op2  output  NUM_BITS  to ALU op2
- alu_status  input  NUM_BITS  ALU registered result (valid one clock after operands are driven)
- done  output  1  one-cycle pulse, instruction retired
- result  output  NUM_BITS  value written back (0 on error)
- err  output  2  valid with done: 0 ok, 1 illegal opcode, 2 divide/mod by zero

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; all register file entries 0.
  - in_ready 1 once rst is released; done 0, result 0, err 0.
  - alu_operator 4'hF (NOP); alu_op1 and alu_op2 0.
  - Any in-flight instruction is discarded with no writeback and no done.
- Legal opcodes: 0 ADD, 1 SUB, 2 MULT, 3 NAND, 4 DIV, 5 MOD, 6 LT, 7 LE. Codes 8..15 are illegal.
- in_ready is 1 only in IDLE. Handshake fires at an edge where in_valid and in_ready are both 1; op/rd/rs1/rs2 are latched at that edge. in_valid may stay high; a new instruction is taken only in IDLE.
- State machine:
  - IDLE -> ISSUE on handshake.
  - ISSUE (1 cycle):
    - Drive alu_operator, alu_op1 = rf[rs1] and alu_op2 = rf[rs2].
    - Illegal opcode: drive NOP, set pending err = 1.
    - Opcode 4 or 5 with rf[rs2] == 0: drive NOP, set pending err = 2.
    - Next state WB.
  - WB (1 cycle):
    - Hold the ALU inputs from ISSUE.
    - If no error, sample alu_status and write rf[rd] at the end-of-cycle edge.
    - Register done = 1, result = alu_status (or 0 on error) and err; next state IDLE.
  - done, result and err are visible in the cycle after WB, which is also the first IDLE cycle (in_ready = 1). done is high for exactly one cycle. result and err hold their values until the next done.
- Latency: handshake at edge E0, ALU inputs driven in cycle E0-E1, rf written at E2, done high in cycle E2-E3. Throughput is 1 instruction per 3 cycles.
- Outside ISSUE/WB, the ALU inputs are NOP/0/0.
- Register file ld_en:
  - Writes rf[ld_addr] = ld_data at the edge, in any state.
  - On the same edge as a WB write to the same address, the WB write wins.
  - A load to rs1/rs2 during ISSUE is seen by a later instruction only. Operands are read combinationally during ISSUE, so a same-edge load is not visible.
- rd equal to rs1 or rs2 is allowed. Operands are read before the writeback.
- Width rules:
  - Results are the ALU's NUM_BITS value.
  - MULT is truncated to the low NUM_BITS bits by the ALU.
  - LT/LE results are 0 or 1, zero-extended.
- dbg_data reflects rf[dbg_addr] combinationally, including a write made at the previous edge.

Test Plan:
- Reset mid-op: start an ADD, assert rst low during WB -> no done, all rf reads 0, in_ready 1 after release, alu_operator 4'hF.
- Load rf[1]=7 and rf[2]=5, issue ADD rd=3 -> done 3 cycles after handshake; result 12, err 0, dbg_data(3) = 12. Issue SUB rd=4 rs1=2 rs2=1 -> result 16'hFFFE.
- Load rf[1]=100 and rf[2]=0, issue DIV rd=5 -> ALU sees NOP, done with err 2, result 0, rf[5] unchanged. MOD with rf[2]=7 -> result 2.
- Issue op 4'h9 -> err 1, rf unchanged. Hold in_valid high continuously -> in_ready 0 during ISSUE/WB, exactly one instruction taken every 3 cycles.
- In WB of ADD rd=3 (result 12), assert ld_en with ld_addr 3 and ld_data 99 -> rf[3] = 12. Repeat with ld_addr 6 -> rf[6] = 99 and rf[3] = 12.
- Load rf[0]=16'hFFFF and rf[1]=2, issue MULT rd=0 -> result 16'hFFFE written to rf[0]. LT rs1=1 rs2=0 -> result 1. LE rs1=0 rs2=1 -> result 0.
